// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// -------------
// Packet source for the 1x3 router. Payload bytes are buffered while idle,
// then sent as one router packet: a header byte {len, addr}, the payload
// bytes, and a parity byte that is the running XOR of header and payload.
// pkt_valid frames the header and payload bytes. busy stalls the byte
// currently presented.
//
// Optional feature macro: ROUTER_PKT_TX_ERR_INJ_EN
//   When defined, the inj_err port exists. Its value is latched at an
//   accepted start, and a latched 1 flips parity bit 0 for that packet.
//
// Parameters:
//   GAP_CYCLES  idle cycles after the parity byte before done (1..15)
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   wr_en      write wr_data into the payload buffer (IDLE only)
//   wr_data    payload byte
//   start      request transmission of the buffered payload
//   addr       destination port 0..2 (3 is refused)
//   busy       router stall; the presented byte is held while high
//   inj_err    parity error injection (macro builds only)
//   data_out   byte to the router data_in
//   pkt_valid  high for the header and payload bytes
//   tx_active  high whenever a packet is in progress
//   done       one-cycle pulse when a packet completes
//   reject     one-cycle pulse when start is refused
//   wr_ovf     one-cycle pulse when a write is dropped on a full buffer
//   wr_count   number of buffered payload bytes
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic       busy,
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    input  logic       inj_err,
`endif
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       reject,
    output logic       wr_ovf,
    output logic [5:0] wr_count
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_e;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] payloadMem_q [64];
    logic [5:0] wrCount_q, wrCount_d;
    logic [5:0] len_q, len_d;
    logic [5:0] rdPtr_q, rdPtr_d;
    logic [7:0] parityAcc_q, parityAcc_d;
    logic [3:0] gapCnt_q, gapCnt_d;
    logic [7:0] dataOut_q, dataOut_d;
    logic       pktValid_q, pktValid_d;
    logic       txActive_q, txActive_d;
    logic       done_q, done_d;
    logic       reject_q, reject_d;
    logic       wrOvf_q, wrOvf_d;
    logic       memWe;
    logic       startOk;
    logic [7:0] headerByte;
    logic [7:0] accNext;
    logic       injErr_q;

    assign startOk    = start && (wrCount_q != 6'd0) && (addr != 2'd3);
    assign headerByte = {wrCount_q, addr};

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    // Error-injection request is captured once per packet at the accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            injErr_q <= 1'b0;
        end else if (state_q == IDLE && startOk) begin
            injErr_q <= inj_err;
        end
    end
`else
    assign injErr_q = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wrCount_q   <= 6'd0;
            len_q       <= 6'd0;
            rdPtr_q     <= 6'd0;
            parityAcc_q <= 8'h00;
            gapCnt_q    <= 4'd0;
            dataOut_q   <= 8'h00;
            pktValid_q  <= 1'b0;
            txActive_q  <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
            wrOvf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrCount_q   <= wrCount_d;
            len_q       <= len_d;
            rdPtr_q     <= rdPtr_d;
            parityAcc_q <= parityAcc_d;
            gapCnt_q    <= gapCnt_d;
            dataOut_q   <= dataOut_d;
            pktValid_q  <= pktValid_d;
            txActive_q  <= txActive_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            wrOvf_q     <= wrOvf_d;
        end
    end

    // Payload storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (memWe) begin
            payloadMem_q[wrCount_q] <= wr_data;
        end
    end

    // Next-state logic. Transfer states advance only when busy is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startOk) state_d = HEADER;
            HEADER:  if (!busy) state_d = PAYLOAD;
            PAYLOAD: if (!busy && rdPtr_q == len_q - 6'd1) state_d = PARITY;
            PARITY:  if (!busy) state_d = GAP;
            GAP:     if (gapCnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output values for the next cycle. The byte placed on
    // data_out_d is the one belonging to state_d, so outputs line up with
    // the registered state.
    always_comb begin
        wrCount_d   = wrCount_q;
        len_d       = len_q;
        rdPtr_d     = rdPtr_q;
        parityAcc_d = parityAcc_q;
        gapCnt_d    = gapCnt_q;
        dataOut_d   = dataOut_q;
        reject_d    = 1'b0;
        wrOvf_d     = 1'b0;
        memWe       = 1'b0;
        accNext     = parityAcc_q ^ payloadMem_q[rdPtr_q];

        case (state_q)
            IDLE: begin
                dataOut_d = 8'h00;
                if (start) begin
                    if (startOk) begin
                        len_d       = wrCount_q;
                        rdPtr_d     = 6'd0;
                        parityAcc_d = headerByte;
                        dataOut_d   = headerByte;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                // An accepted start wins over a simultaneous write.
                if (wr_en && !startOk) begin
                    if (wrCount_q != 6'd63) begin
                        memWe     = 1'b1;
                        wrCount_d = wrCount_q + 6'd1;
                    end else begin
                        wrOvf_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (!busy) dataOut_d = payloadMem_q[6'd0];
            end
            PAYLOAD: begin
                if (!busy) begin
                    parityAcc_d = accNext;
                    if (rdPtr_q == len_q - 6'd1) begin
                        dataOut_d = accNext ^ {7'b0, injErr_q};
                    end else begin
                        rdPtr_d   = rdPtr_q + 6'd1;
                        dataOut_d = payloadMem_q[rdPtr_q + 6'd1];
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    dataOut_d = 8'h00;
                    gapCnt_d  = 4'd0;
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    wrCount_d = 6'd0;
                end else begin
                    gapCnt_d = gapCnt_q + 4'd1;
                end
            end
            default: dataOut_d = 8'h00;
        endcase

        // done marks the final GAP cycle.
        done_d     = (state_d == GAP) && (gapCnt_d == GAP_LAST);
        pktValid_d = (state_d == HEADER) || (state_d == PAYLOAD);
        txActive_d = (state_d != IDLE);
    end

    assign data_out  = dataOut_q;
    assign pkt_valid = pktValid_q;
    assign tx_active = txActive_q;
    assign done      = done_q;
    assign reject    = reject_q;
    assign wr_ovf    = wrOvf_q;
    assign wr_count  = wrCount_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx
// ----------------
// Directed bench for router_pkt_tx with GAP_CYCLES = 1. Inputs change 1 ns
// after a rising edge and outputs are checked at that point, so each check
// sees the cycle that the preceding edge produced.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] addr;
    logic       busy;
    logic       inj_err;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       reject;
    logic       wr_ovf;
    logic [5:0] wr_count;

    int compareCount  = 0;
    int mismatchCount = 0;

    router_pkt_tx #(.GAP_CYCLES(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .addr      (addr),
        .busy      (busy),
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        .inj_err   (inj_err),
`endif
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_active (tx_active),
        .done      (done),
        .reject    (reject),
        .wr_ovf    (wr_ovf),
        .wr_count  (wr_count)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Write one payload byte.
    task automatic applyStimulus(input logic [7:0] value);
        wr_en   = 1'b1;
        wr_data = value;
        stepCycle();
        wr_en   = 1'b0;
    endtask

    // Check the presented byte and its framing.
    task automatic checkByte(input string tag, input logic [7:0] value, input logic valid);
        checkOutput({tag, "_data"}, {24'h0, data_out}, {24'h0, value});
        checkOutput({tag, "_valid"}, {31'h0, pkt_valid}, {31'h0, valid});
    endtask

    // Load 0x11, 0x22, 0x33 and start toward addr.
    task automatic loadAndStart(input logic [1:0] dest);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        start = 1'b1;
        addr  = dest;
        stepCycle();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] expParity;
        int ovfPulses;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        start   = 1'b0;
        addr    = 2'd0;
        busy    = 1'b0;
        inj_err = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b0;

        checkOutput("rst_data",   {24'h0, data_out}, 32'h00);
        checkOutput("rst_valid",  {31'h0, pkt_valid}, 32'h0);
        checkOutput("rst_active", {31'h0, tx_active}, 32'h0);
        checkOutput("rst_done",   {31'h0, done}, 32'h0);
        checkOutput("rst_reject", {31'h0, reject}, 32'h0);
        checkOutput("rst_ovf",    {31'h0, wr_ovf}, 32'h0);
        checkOutput("rst_count",  {26'h0, wr_count}, 32'h0);

        // Basic packet to port 1: header 0x0D, parity 0x0D.
        $display("[TB] basic packet");
        loadAndStart(2'd1);
        checkByte("p1_hdr", 8'h0D, 1'b1);
        checkOutput("p1_active", {31'h0, tx_active}, 32'h1);
        stepCycle(); checkByte("p1_b0", 8'h11, 1'b1);
        stepCycle(); checkByte("p1_b1", 8'h22, 1'b1);
        stepCycle(); checkByte("p1_b2", 8'h33, 1'b1);
        stepCycle(); checkByte("p1_par", 8'h0D, 1'b0);
        checkOutput("p1_done_early", {31'h0, done}, 32'h0);
        stepCycle();
        checkOutput("p1_done", {31'h0, done}, 32'h1);
        checkOutput("p1_gap_valid", {31'h0, pkt_valid}, 32'h0);
        stepCycle();
        checkOutput("p1_done_once", {31'h0, done}, 32'h0);
        checkOutput("p1_idle", {31'h0, tx_active}, 32'h0);
        checkOutput("p1_count", {26'h0, wr_count}, 32'h0);

        // Same packet with busy held for three cycles on 0x22.
        $display("[TB] busy stall");
        loadAndStart(2'd1);
        checkByte("p2_hdr", 8'h0D, 1'b1);
        stepCycle(); checkByte("p2_b0", 8'h11, 1'b1);
        stepCycle(); checkByte("p2_b1", 8'h22, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkByte("p2_hold", 8'h22, 1'b1);
        end
        busy = 1'b0;
        stepCycle(); checkByte("p2_b2", 8'h33, 1'b1);
        stepCycle(); checkByte("p2_par", 8'h0D, 1'b0);
        stepCycle(); checkOutput("p2_done", {31'h0, done}, 32'h1);
        stepCycle(); checkOutput("p2_count", {26'h0, wr_count}, 32'h0);

        // Refused starts: empty buffer, then illegal address.
        $display("[TB] reject cases");
        start = 1'b1; addr = 2'd0;
        stepCycle();
        start = 1'b0;
        checkOutput("rej_empty", {31'h0, reject}, 32'h1);
        checkOutput("rej_empty_idle", {31'h0, tx_active}, 32'h0);
        stepCycle();
        checkOutput("rej_pulse", {31'h0, reject}, 32'h0);
        applyStimulus(8'h5A);
        start = 1'b1; addr = 2'd3;
        stepCycle();
        start = 1'b0;
        checkOutput("rej_addr", {31'h0, reject}, 32'h1);
        checkOutput("rej_addr_idle", {31'h0, tx_active}, 32'h0);
        checkOutput("rej_keep", {26'h0, wr_count}, 32'h1);

        // Full buffer: 64 writes, one overflow, then a 63-byte packet.
        $display("[TB] full buffer");
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        ovfPulses = 0;
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            stepCycle();
            if (wr_ovf) ovfPulses++;
        end
        wr_en = 1'b0;
        stepCycle();
        if (wr_ovf) ovfPulses++;
        checkOutput("full_count", {26'h0, wr_count}, 32'd63);
        checkOutput("full_ovf_pulses", ovfPulses, 32'd1);
        start = 1'b1; addr = 2'd2;
        stepCycle();
        start = 1'b0;
        checkByte("full_hdr", 8'hFE, 1'b1);
        expParity = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            stepCycle();
            checkByte("full_payload", 8'(i), 1'b1);
            expParity = expParity ^ 8'(i);
        end
        stepCycle();
        checkByte("full_par", expParity, 1'b0);
        checkOutput("full_par_const", {24'h0, data_out}, 32'hC1);
        stepCycle();
        checkOutput("full_done", {31'h0, done}, 32'h1);
        stepCycle();

        // Reset while the second payload byte is presented.
        $display("[TB] reset mid-packet");
        loadAndStart(2'd0);
        checkByte("abort_hdr", 8'h0C, 1'b1);
        stepCycle(); checkByte("abort_b0", 8'h11, 1'b1);
        stepCycle(); checkByte("abort_b1", 8'h22, 1'b1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("abort_valid", {31'h0, pkt_valid}, 32'h0);
        checkOutput("abort_active", {31'h0, tx_active}, 32'h0);
        checkOutput("abort_count", {26'h0, wr_count}, 32'h0);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("abort_no_done", {31'h0, done}, 32'h0);
        end

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        // Injected parity error: bit 0 of parity flips, 0x0D becomes 0x0C.
        $display("[TB] parity injection");
        inj_err = 1'b1;
        loadAndStart(2'd1);
        inj_err = 1'b0;
        checkByte("inj_hdr", 8'h0D, 1'b1);
        stepCycle(); checkByte("inj_b0", 8'h11, 1'b1);
        stepCycle(); checkByte("inj_b1", 8'h22, 1'b1);
        stepCycle(); checkByte("inj_b2", 8'h33, 1'b1);
        stepCycle(); checkByte("inj_par", 8'h0C, 1'b0);
        stepCycle(); checkOutput("inj_done", {31'h0, done}, 32'h1);
        stepCycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
